// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM states and memory-control bit positions for the EX/MEM skid stage.
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  localparam int M_MEMREAD = 0;
  localparam int M_MEMWRITE = 1;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: payload register plus valid flag with load, clear and reset.
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         v_o
);
  // Clear only drops the valid flag; payload is retained so invalid outputs hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= '0;
      v_o <= 1'b0;
    end else if (clr_i) begin
      v_o <= 1'b0;
    end else if (ld_i) begin
      q_o <= d_i;
      v_o <= 1'b1;
    end
  end
endmodule

// File: rtl/exmem_skid_stage.sv
// exmem_skid_stage: EX/MEM pipeline latch with valid/ready, two-entry skid buffer and flush.
module exmem_skid_stage
  import pipe_pkg::*;
#(
  parameter int WB_W = 2,
  parameter int M_W = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [M_W-1:0]    M_i,
  input  logic [DATA_W-1:0] RegData_i,
  input  logic [DATA_W-1:0] MemData_i,
  input  logic [ADDR_W-1:0] RegAddr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [M_W-1:0]    M_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [DATA_W-1:0] RegData_o,
  output logic [DATA_W-1:0] MemData_o,
  output logic [ADDR_W-1:0] RegAddr_o,
  output logic [1:0]        occ_o
);
  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] regData;
    logic [DATA_W-1:0] memData;
    logic [ADDR_W-1:0] regAddr;
  } payload_t;
  localparam int PW = $bits(payload_t);
  state_t state, nextState;
  payload_t inP, mainP, skidP, mainD;
  logic mainV, skidV, inXfer, outXfer, mainLd, mainClr, skidLd, skidClr, readyQ;
  assign inP = '{wb: WB_i, m: M_i, regData: RegData_i, memData: MemData_i, regAddr: RegAddr_i};
  assign ready_o = readyQ;
  assign valid_o = mainV;
  assign inXfer = valid_i & readyQ;
  assign outXfer = mainV & ready_i;
  // Flush suppresses every load so a same-cycle offer is discarded.
  assign mainLd = !flush_i & ((state == EMPTY & inXfer) | (state == ONE & inXfer & outXfer) |
                              (state == FULL & outXfer & skidV));
  assign mainD = state == FULL ? skidP : inP;
  assign mainClr = flush_i | (state == ONE & outXfer & !inXfer);
  assign skidLd = !flush_i & state == ONE & inXfer & !outXfer;
  assign skidClr = flush_i | (state == FULL & outXfer);
  always_comb begin
    nextState = state;
    if (flush_i) nextState = EMPTY;
    else if (state == EMPTY) nextState = inXfer ? ONE : EMPTY;
    else if (state == ONE) nextState = inXfer && !outXfer ? FULL : (!inXfer && outXfer ? EMPTY : ONE);
    else nextState = outXfer ? ONE : FULL;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= EMPTY;
      readyQ <= 1'b1;
    end else begin
      state <= nextState;
      readyQ <= nextState != FULL;
    end
  end
  pipe_entry_reg #(.W(PW)) mainReg (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(mainClr), .ld_i(mainLd),
    .d_i(mainD), .q_o(mainP), .v_o(mainV)
  );
  pipe_entry_reg #(.W(PW)) skidReg (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(skidClr), .ld_i(skidLd),
    .d_i(inP), .q_o(skidP), .v_o(skidV)
  );
  // Control fields are gated so bubbles can never read or write memory.
  assign WB_o = mainV ? mainP.wb : '0;
  assign M_o = mainV ? mainP.m : '0;
  assign MemRead_o = M_o[M_MEMREAD];
  assign MemWrite_o = M_o[M_MEMWRITE];
  assign RegData_o = mainP.regData;
  assign MemData_o = mainP.memData;
  assign RegAddr_o = mainP.regAddr;
  assign occ_o = state;
endmodule

// File: tb/tb_exmem_skid_stage.sv
// tb_exmem_skid_stage: queue-based reference model plus directed and random stimulus.
module tb_exmem_skid_stage;
  logic clk = 1'b0;
  logic rst_i, flush_i, valid_i, ready_i;
  logic [1:0] WB_i, M_i;
  logic [31:0] RegData_i, MemData_i;
  logic [4:0] RegAddr_i;
  logic ready_o, valid_o, MemRead_o, MemWrite_o;
  logic [1:0] WB_o, M_o, occ_o;
  logic [31:0] RegData_o, MemData_o;
  logic [4:0] RegAddr_o;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  exmem_skid_stage dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .WB_i(WB_i), .M_i(M_i), .RegData_i(RegData_i), .MemData_i(MemData_i), .RegAddr_i(RegAddr_i),
    .valid_o(valid_o), .ready_i(ready_i), .WB_o(WB_o), .M_o(M_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .RegData_o(RegData_o), .MemData_o(MemData_o), .RegAddr_o(RegAddr_o),
    .occ_o(occ_o)
  );

  typedef struct packed {
    logic [1:0] wb;
    logic [1:0] m;
    logic [31:0] rd;
    logic [31:0] md;
    logic [4:0] ra;
  } ent_t;

  ent_t q[$];
  ent_t last;
  logic expReady;
  bit live = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Model: a FIFO of at most two accepted entries; the head is what MEM sees.
  always @(posedge clk) begin
    ent_t inE;
    logic inX, outX;
    inE = '{WB_i, M_i, RegData_i, MemData_i, RegAddr_i};
    inX = valid_i && expReady;
    outX = q.size() > 0 && ready_i;
    if (rst_i) begin
      q.delete();
      last = '0;
      expReady = 1'b1;
      live = 1;
    end else if (live) begin
      if (flush_i) q.delete();
      else begin
        if (outX) void'(q.pop_front());
        if (inX) q.push_back(inE);
      end
      expReady = q.size() < 2;
    end
    if (q.size() > 0) last = q[0];
  end

  always @(negedge clk) begin
    if (live) begin
      ent_t e;
      logic v;
      v = q.size() > 0;
      e = v ? q[0] : last;
      chk("valid_o", valid_o, v);
      chk("ready_o", ready_o, expReady);
      chk("occ_o", occ_o, q.size());
      chk("WB_o", WB_o, v ? e.wb : 2'b0);
      chk("M_o", M_o, v ? e.m : 2'b0);
      chk("MemRead_o", MemRead_o, v & e.m[0]);
      chk("MemWrite_o", MemWrite_o, v & e.m[1]);
      chk("RegData_o", RegData_o, e.rd);
      chk("MemData_o", MemData_o, e.md);
      chk("RegAddr_o", RegAddr_o, e.ra);
    end
  end

  task automatic drive(input logic v, input logic [31:0] rd, input logic rdy);
    valid_i = v;
    RegData_i = rd;
    ready_i = rdy;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1; flush_i = 0; valid_i = 0; ready_i = 1;
    WB_i = 0; M_i = 0; RegData_i = 0; MemData_i = 0; RegAddr_i = 0;
    tick; tick;
    chk("rst valid_o", valid_o, 0);
    chk("rst ready_o", ready_o, 1);
    chk("rst RegData_o", RegData_o, 0);
    chk("rst occ_o", occ_o, 0);
    rst_i = 0; WB_i = 2'b10; M_i = 2'b01; MemData_i = 32'hDEAD_BEEF; RegAddr_i = 5'd7;
    drive(1, 32'h1234, 1);
    tick;
    chk("first valid_o", valid_o, 1);
    chk("first MemRead_o", MemRead_o, 1);
    chk("first MemWrite_o", MemWrite_o, 0);
    chk("first RegAddr_o", RegAddr_o, 7);
    chk("first RegData_o", RegData_o, 32'h1234);
    for (int i = 1; i <= 8; i++) begin
      drive(1, i, 1);
      tick;
      chk("stream RegData_o", RegData_o, i);
      chk("stream occ_o", occ_o, 1);
    end
    drive(0, 0, 1);
    tick;
    drive(1, 32'hA, 1);
    tick;
    drive(1, 32'hB, 0);
    tick;
    chk("skid occ_o", occ_o, 2);
    chk("skid ready_o", ready_o, 0);
    chk("skid hold A", RegData_o, 32'hA);
    drive(0, 0, 1);
    tick;
    chk("skid B next", RegData_o, 32'hB);
    chk("skid ready back", ready_o, 1);
    tick;
    chk("skid drained", valid_o, 0);
    M_i = 2'b10;
    drive(1, 32'hD, 0);
    tick;
    drive(1, 32'hE, 0);
    tick;
    chk("pre-flush occ_o", occ_o, 2);
    flush_i = 1;
    drive(1, 32'hC, 0);
    tick;
    flush_i = 0;
    chk("flush valid_o", valid_o, 0);
    chk("flush occ_o", occ_o, 0);
    chk("flush ready_o", ready_o, 1);
    chk("flush WB_o", WB_o, 0);
    chk("flush MemWrite_o", MemWrite_o, 0);
    drive(0, 0, 1);
    tick;
    chk("C dropped", valid_o, 0);
    drive(1, 32'h11, 0);
    tick;
    drive(1, 32'h22, 0);
    tick;
    rst_i = 1;
    drive(0, 0, 0);
    tick;
    rst_i = 0;
    chk("midrst RegData_o", RegData_o, 0);
    chk("midrst valid_o", valid_o, 0);
    chk("midrst ready_o", ready_o, 1);
    chk("midrst occ_o", occ_o, 0);
    drive(1, 32'hF, 1);
    tick;
    chk("post-rst entry", RegData_o, 32'hF);
    chk("post-rst valid", valid_o, 1);
    M_i = 2'b11;
    drive(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bubble MemRead_o", MemRead_o, 0);
      chk("bubble MemWrite_o", MemWrite_o, 0);
      chk("bubble valid_o", valid_o, 0);
    end
    for (int i = 0; i < 3000; i++) begin
      valid_i = ($urandom % 4) != 0;
      ready_i = ($urandom % 3) != 0;
      flush_i = ($urandom % 25) == 0;
      rst_i = ($urandom % 200) == 0;
      WB_i = 2'($urandom);
      M_i = 2'($urandom);
      RegData_i = $urandom;
      MemData_i = $urandom;
      RegAddr_i = 5'($urandom);
      tick;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
